// File: rtl/call_frame_stack_pkg.sv
// Shared core constants: trap codes, value types and call-frame request opcodes.
package call_frame_stack_pkg;

    typedef enum logic [3:0] {
        TRAP_NONE                 = 4'd0,
        TRAP_NO_64B               = 4'd1,
        TRAP_CALL_STACK_EXHAUSTED = 4'd2,
        TRAP_NO_TAIL_CALL         = 4'd3
    } trap_e;

    typedef enum logic [1:0] {
        TYPE_I32 = 2'd0,
        TYPE_I64 = 2'd1
    } val_type_e;

    typedef enum logic [1:0] {
        OP_NOP       = 2'd0,
        OP_CALL      = 2'd1,
        OP_RETURN    = 2'd2,
        OP_TAIL_CALL = 2'd3
    } op_e;

endpackage

// File: rtl/call_frame_stack_ram.sv
// Frame storage: one synchronous write port, one registered read port, no reset.
module call_frame_stack_ram #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/call_frame_stack.sv
// Call-frame stack: saves {return pc, operand-stack index} per CALL, restores on RETURN.
module call_frame_stack
    import call_frame_stack_pkg::*;
#(
    parameter int MEM_DEPTH     = 6,
    parameter int STACK_DEPTH   = 7,
    parameter int FRAME_DEPTH   = 4,
    parameter bit HAS_TAIL_CALL = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [1:0]             req_op,
    input  logic [MEM_DEPTH:0]     req_pc,
    input  logic [STACK_DEPTH:0]   req_index,
    output logic                   pop_valid,
    output logic [MEM_DEPTH:0]     pop_pc,
    output logic [STACK_DEPTH:0]   pop_index,
    output logic [FRAME_DEPTH:0]   depth,
    output logic [FRAME_DEPTH:0]   max_depth,
    output logic                   done,
    output logic [3:0]             trap
);

    localparam int FW = MEM_DEPTH + STACK_DEPTH + 2;
    localparam logic [FRAME_DEPTH:0]   FULL  = {1'b1, {FRAME_DEPTH{1'b0}}};
    localparam logic [FRAME_DEPTH:0]   D_ONE = (FRAME_DEPTH+1)'(1);
    localparam logic [FRAME_DEPTH-1:0] A_ONE = FRAME_DEPTH'(1);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_HALT} state_e;

    state_e                 state_q, state_d;
    logic [FRAME_DEPTH:0]   depth_q, depth_d, max_q, max_d, depth_inc;
    logic                   pop_valid_q, pop_valid_d, done_q, done_d;
    logic [MEM_DEPTH:0]     pop_pc_q, pop_pc_d;
    logic [STACK_DEPTH:0]   pop_index_q, pop_index_d;
    trap_e                  trap_q, trap_d;

    logic                   we, re, accept;
    logic [FRAME_DEPTH-1:0] waddr, raddr;
    logic [FW-1:0]          rdata;

    assign req_ready = reset && (state_q == S_IDLE);
    assign accept    = req_valid && req_ready;
    assign depth_inc = depth_q + D_ONE;
    // Addresses use only the low bits: a write never happens at FULL, and
    // depth-1 from FULL lands on the top entry after truncation.
    assign waddr     = depth_q[FRAME_DEPTH-1:0];
    assign raddr     = depth_q[FRAME_DEPTH-1:0] - A_ONE;

    call_frame_stack_ram #(
        .ADDR_W (FRAME_DEPTH),
        .DATA_W (FW)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i ({req_pc, req_index}),
        .re_i    (re),
        .raddr_i (raddr),
        .rdata_o (rdata)
    );

    always_comb begin
        state_d     = state_q;
        depth_d     = depth_q;
        max_d       = max_q;
        pop_valid_d = 1'b0;
        pop_pc_d    = pop_pc_q;
        pop_index_d = pop_index_q;
        done_d      = done_q;
        trap_d      = trap_q;
        we          = 1'b0;
        re          = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (op_e'(req_op))
                        OP_CALL: begin
                            if (depth_q == FULL) begin
                                trap_d  = TRAP_CALL_STACK_EXHAUSTED;
                                state_d = S_HALT;
                            end else begin
                                we      = 1'b1;
                                depth_d = depth_inc;
                                if (depth_inc > max_q) max_d = depth_inc;
                            end
                        end
                        OP_RETURN: begin
                            if (depth_q == '0) begin
                                done_d  = 1'b1;
                                state_d = S_HALT;
                            end else begin
                                re      = 1'b1;
                                depth_d = depth_q - D_ONE;
                                state_d = S_READ;
                            end
                        end
                        OP_TAIL_CALL: begin
                            if (!HAS_TAIL_CALL) begin
                                trap_d  = TRAP_NO_TAIL_CALL;
                                state_d = S_HALT;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_READ: begin
                pop_valid_d = 1'b1;
                pop_pc_d    = rdata[FW-1:STACK_DEPTH+1];
                pop_index_d = rdata[STACK_DEPTH:0];
                state_d     = S_IDLE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            depth_q     <= '0;
            max_q       <= '0;
            pop_valid_q <= 1'b0;
            pop_pc_q    <= '0;
            pop_index_q <= '0;
            done_q      <= 1'b0;
            trap_q      <= TRAP_NONE;
        end else begin
            state_q     <= state_d;
            depth_q     <= depth_d;
            max_q       <= max_d;
            pop_valid_q <= pop_valid_d;
            pop_pc_q    <= pop_pc_d;
            pop_index_q <= pop_index_d;
            done_q      <= done_d;
            trap_q      <= trap_d;
        end
    end

    assign pop_valid = pop_valid_q;
    assign pop_pc    = pop_pc_q;
    assign pop_index = pop_index_q;
    assign depth     = depth_q;
    assign max_depth = max_q;
    assign done      = done_q;
    assign trap      = trap_q;

endmodule
